// File: rtl/rv_muldiv_pkg.sv
// rv_muldiv_pkg: shared constants for the iterative RISC-V M-extension unit.
//   MD_XLEN   operand/result width (only 32 is supported)
//   MD_ITERS  datapath iterations per multiply/divide
//   MD_*      funct3 encodings of the M-extension operations
//   ST_*      FSM state encodings of rv_muldiv
package rv_muldiv_pkg;

  localparam int unsigned MD_XLEN  = 32;
  localparam int unsigned MD_ITERS = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/rv_muldiv_if.sv
// rv_muldiv_if: request / register-writeback bundle between the core and rv_muldiv.
//   start, funct3, rs1_val, rs2_val, rd, kill : core -> unit
//   busy, wb_en, wb_addr, wb_data             : unit -> core / register file
// master = core side, slave = rv_muldiv side.
interface rv_muldiv_if;
  import rv_muldiv_pkg::*;

  logic               start;
  logic [2:0]         funct3;
  logic [MD_XLEN-1:0] rs1_val;
  logic [MD_XLEN-1:0] rs2_val;
  logic [4:0]         rd;
  logic               kill;
  logic               busy;
  logic               wb_en;
  logic [4:0]         wb_addr;
  logic [MD_XLEN-1:0] wb_data;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd, kill,
    input  busy, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd, kill,
    output busy, wb_en, wb_addr, wb_data
  );

endinterface

// File: rtl/rv_muldiv_iter.sv
// rv_muldiv_iter: one-bit-per-cycle datapath shared by multiply and divide.
//   clk, rst   clock, synchronous active-high reset
//   i_load     load magnitudes and clear the iteration counter
//   i_step     perform one iteration this cycle
//   i_is_div   operation kind latched on load (0 shift-add, 1 restoring divide)
//   i_mag1     multiplier / dividend magnitude
//   i_mag2     multiplicand / divisor magnitude
//   o_acc      accumulator including this cycle's iteration
//              (multiply: 64-bit product; divide: {remainder, quotient})
//   o_last     current iteration is the final one
module rv_muldiv_iter
  import rv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = MD_XLEN,
  parameter int unsigned ITERS = MD_ITERS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_mag1,
  input  logic [XLEN-1:0]   i_mag2,
  output logic [2*XLEN-1:0] o_acc,
  output logic              o_last
);

  localparam int unsigned CW = $clog2(ITERS);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic              r_is_div;
  logic [CW-1:0]     r_cnt;

  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [2*XLEN-1:0] w_div_nxt;

  assign w_hi = r_acc[2*XLEN-1:XLEN];
  assign w_lo = r_acc[XLEN-1:0];

  // Shift-add: low half starts as the multiplier and is consumed LSB first
  // while product bits shift in from the top.
  assign w_sum     = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opb} : '0);
  assign w_mul_nxt = {w_sum, w_lo[XLEN-1:1]};

  // Restoring divide: the partial remainder stays below the divisor, so the
  // shifted value fits XLEN+1 bits and the top bit of the difference is its sign.
  assign w_shift   = {w_hi, w_lo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_opb};
  assign w_ge      = ~w_diff[XLEN];
  assign w_div_nxt = {(w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]), w_lo[XLEN-2:0], w_ge};

  assign o_acc  = r_is_div ? w_div_nxt : w_mul_nxt;
  assign o_last = (r_cnt == CW'(ITERS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= {{XLEN{1'b0}}, i_mag1};
      r_opb    <= i_mag2;
      r_is_div <= i_is_div;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc <= o_acc;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rv_muldiv.sv
// rv_muldiv: iterative RISC-V M-extension unit feeding the register-file write port.
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   rv_muldiv_if.slave: start/funct3/rs1_val/rs2_val/rd/kill in,
//         busy/wb_en/wb_addr/wb_data out
// Operands are reduced to magnitudes at start; the iteration datapath works
// unsigned and the result sign is restored as the unit enters DONE.
// Divide-by-zero and signed overflow bypass the iterations (1-cycle latency).
module rv_muldiv
  import rv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic        clk,
  input  logic        rst,
  rv_muldiv_if.slave  bus
);

  logic [1:0]      r_state;
  logic [2:0]      r_f3;
  logic [4:0]      r_rd;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [4:0]      r_wb_addr;
  logic [XLEN-1:0] r_wb_data;

  logic [2:0]        w_f3;
  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_b;
  logic              w_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_accept;
  logic [2*XLEN-1:0] w_acc;
  logic              w_last;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_result;

  assign w_f3     = bus.funct3;
  assign w_a      = bus.rs1_val;
  assign w_b      = bus.rs2_val;
  assign w_is_div = w_f3[2];

  assign w_a_signed = (w_f3 == MD_MUL) || (w_f3 == MD_MULH) || (w_f3 == MD_MULHSU) ||
                      (w_f3 == MD_DIV) || (w_f3 == MD_REM);
  assign w_b_signed = (w_f3 == MD_MUL) || (w_f3 == MD_MULH) ||
                      (w_f3 == MD_DIV) || (w_f3 == MD_REM);

  assign w_a_neg = w_a_signed & w_a[XLEN-1];
  assign w_b_neg = w_b_signed & w_b[XLEN-1];
  assign w_mag1  = w_a_neg ? -w_a : w_a;
  assign w_mag2  = w_b_neg ? -w_b : w_b;

  assign w_div0 = w_is_div & (w_b == '0);
  assign w_ovf  = w_is_div & ~w_f3[0] & (w_a == {1'b1, {(XLEN-1){1'b0}}}) & (w_b == '1);
  assign w_fast = w_div0 | w_ovf;

  // funct3[1] separates REM/REMU from DIV/DIVU within the divide group.
  always_comb begin
    w_fast_res = '0;
    if (w_div0) begin
      w_fast_res = w_f3[1] ? w_a : '1;
    end else begin
      w_fast_res = w_f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  assign w_accept = (r_state == ST_IDLE) & bus.start & ~bus.kill;

  rv_muldiv_iter #(
    .XLEN  (XLEN),
    .ITERS (MD_ITERS)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_accept & ~w_fast),
    .i_step   (r_state == ST_RUN),
    .i_is_div (w_is_div),
    .i_mag1   (w_mag1),
    .i_mag2   (w_mag2),
    .o_acc    (w_acc),
    .o_last   (w_last)
  );

  // Sign fix works on the accumulator value of the final iteration, so the
  // corrected result can be registered on the same edge that enters DONE.
  assign w_prod = r_neg_q ? -w_acc : w_acc;
  assign w_quo  = r_neg_q ? -w_acc[XLEN-1:0] : w_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? -w_acc[2*XLEN-1:XLEN] : w_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_result = '0;
    case (r_f3)
      MD_MUL:                       w_result = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_result = w_quo;
      default:                      w_result = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_f3      <= '0;
      r_rd      <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_f3    <= w_f3;
            r_rd    <= bus.rd;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_fast) begin
              r_wb_addr <= bus.rd;
              r_wb_data <= w_fast_res;
              r_state   <= ST_DONE;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bus.kill) begin
            r_state <= ST_IDLE;
          end else if (w_last) begin
            r_wb_addr <= r_rd;
            r_wb_data <= w_result;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.wb_en   = (r_state == ST_DONE) & (r_wb_addr != '0) & ~bus.kill;
  assign bus.wb_addr = r_wb_addr;
  assign bus.wb_data = r_wb_data;

endmodule

// File: tb/tb_rv_muldiv.sv
// tb_rv_muldiv: self-checking bench for rv_muldiv.
// A behavioural model (plain 64-bit arithmetic plus a cycle countdown) predicts
// busy/wb_en/wb_addr/wb_data every cycle; directed vectors carry hand-computed
// results and latencies; a randomized phase exercises all ops, kills and
// corner operands.
module tb_rv_muldiv;
  import rv_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_muldiv_if bus ();

  rv_muldiv #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Reference result straight from the M-extension definitions.
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic signed [31:0] q;
    logic [31:0] u;
    case (f)
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU: begin
        sa = (f == MD_MULHU) ? {32'b0, a} : {{32{a[31]}}, a};
        sb = (f == MD_MUL || f == MD_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = sa * sb;
        return (f == MD_MUL) ? p[31:0] : p[63:32];
      end
      MD_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = $signed(a) / $signed(b);
        return q;
      end
      MD_DIVU: begin
        if (b == 0) return 32'hFFFFFFFF;
        u = a / b;
        return u;
      end
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: begin
        if (b == 0) return a;
        u = a % b;
        return u;
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Model: m_left = busy cycles remaining including the current one (1 = DONE).
  int          m_left  = 0;
  bit          m_valid = 0;
  logic [4:0]  m_rd    = '0;
  logic [31:0] m_res   = '0;
  logic [4:0]  m_oaddr = '0;
  logic [31:0] m_odata = '0;

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (m_valid) begin
        check1("busy", bus.busy, m_left > 0);
        check1("wb_en", bus.wb_en, (m_left == 1) && (m_rd != 0) && !bus.kill);
        check32("wb_addr", {27'b0, bus.wb_addr}, {27'b0, m_oaddr});
        check32("wb_data", bus.wb_data, m_odata);
      end
      if (rst) begin
        m_left  = 0;
        m_oaddr = '0;
        m_odata = '0;
        m_valid = 1;
      end else if (m_left == 0) begin
        if (bus.start && !bus.kill) begin
          m_res = ref_md(bus.funct3, bus.rs1_val, bus.rs2_val);
          m_rd  = bus.rd;
          if (is_fast(bus.funct3, bus.rs1_val, bus.rs2_val)) begin
            m_left  = 1;
            m_oaddr = m_rd;
            m_odata = m_res;
          end else begin
            m_left = 33;
          end
        end
      end else if (bus.kill) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 1) begin
          m_oaddr = m_rd;
          m_odata = m_res;
        end
      end
    end
  end

  // Issue one operation at the next edge. kill_at = -1 raises kill with start;
  // kill_at/rst_at/bsy_at = n act in cycle T+n. Returns first wb_en cycle/data
  // and the first cycle busy is low.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input int kill_at, input int rst_at,
                        input int bsy_at, output int lat, output logic [31:0] data,
                        output logic [4:0] addr, output bit seen, output int idle_at);
    bit done;
    lat = 0; data = '0; addr = '0; seen = 0; idle_at = 0; done = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.kill    = (kill_at < 0);
    bus.funct3  = f;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd      = d;
    @(negedge clk);
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
    bus.rd      = 5'($urandom);
    bus.funct3  = 3'($urandom);
    for (int n = 1; n <= 40; n++) begin
      bus.kill  = (n == kill_at);
      rst       = (n == rst_at);
      bus.start = (n == bsy_at);
      #4;
      if (bus.wb_en && !seen) begin
        seen = 1;
        lat  = n;
        data = bus.wb_data;
        addr = bus.wb_addr;
      end
      if (!bus.busy) begin
        done    = 1;
        idle_at = n;
        break;
      end
      @(negedge clk);
    end
    check1("timeout", done, 1'b1);
    bus.kill  = 1'b0;
    bus.start = 1'b0;
    rst       = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    int          k;
    int          r;
    int          bs;
    bit          es;
    int          el;
    logic [31:0] ed;
    int          ei;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  initial begin
    int          lat, idle_at;
    logic [31:0] data;
    logic [4:0]  addr;
    bit          seen;

    vt[0]  = '{MD_MUL,    32'd7,          32'hFFFFFFFD, 5'd5,  0, 0, 0, 1, 33, 32'hFFFFFFEB, 34};
    vt[1]  = '{MD_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd1,  0, 0, 0, 1, 33, 32'hFFFFFFFE, 34};
    vt[2]  = '{MD_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 5'd1,  0, 0, 0, 1, 33, 32'h00000000, 34};
    vt[3]  = '{MD_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd1,  0, 0, 0, 1, 33, 32'hFFFFFFFF, 34};
    vt[4]  = '{MD_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 5'd1,  0, 0, 0, 1, 33, 32'h00000001, 34};
    vt[5]  = '{MD_DIV,    32'hFFFFFFF9,   32'd2,        5'd2,  0, 0, 0, 1, 33, 32'hFFFFFFFD, 34};
    vt[6]  = '{MD_REM,    32'hFFFFFFF9,   32'd2,        5'd2,  0, 0, 0, 1, 33, 32'hFFFFFFFF, 34};
    vt[7]  = '{MD_DIVU,   32'd100,        32'd7,        5'd3,  0, 0, 0, 1, 33, 32'd14,       34};
    vt[8]  = '{MD_REMU,   32'd100,        32'd7,        5'd3,  0, 0, 0, 1, 33, 32'd2,        34};
    vt[9]  = '{MD_DIV,    32'd5,          32'd0,        5'd4,  0, 0, 0, 1, 1,  32'hFFFFFFFF, 2};
    vt[10] = '{MD_REMU,   32'd5,          32'd0,        5'd4,  0, 0, 0, 1, 1,  32'd5,        2};
    vt[11] = '{MD_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd6,  0, 0, 0, 1, 1,  32'h80000000, 2};
    vt[12] = '{MD_REM,    32'h80000000,   32'hFFFFFFFF, 5'd6,  0, 0, 0, 1, 1,  32'h00000000, 2};
    vt[13] = '{MD_MUL,    32'd9,          32'd9,        5'd8,  10, 0, 0, 0, 0, 32'h0,        11};
    vt[14] = '{MD_MUL,    32'd6,          32'd7,        5'd9,  0, 0, 5, 1, 33, 32'd42,       34};
    vt[15] = '{MD_DIVU,   32'd100,        32'd7,        5'd0,  0, 0, 0, 0, 0,  32'h0,        34};
    vt[16] = '{MD_MUL,    32'd1,          32'd1,        5'd10, 0, 5, 0, 0, 0,  32'h0,        6};
    vt[17] = '{MD_MUL,    32'd3,          32'd4,        5'd7,  0, 0, 0, 1, 33, 32'd12,       34};
    vt[18] = '{MD_MUL,    32'd5,          32'd5,        5'd11, -1, 0, 0, 0, 0, 32'h0,        1};

    rst = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = '0;
    bus.rs1_val = '0; bus.rs2_val = '0; bus.rd = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #4;
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_wb_en", bus.wb_en, 1'b0);
    check32("rst_wb_addr", {27'b0, bus.wb_addr}, 32'h0);
    check32("rst_wb_data", bus.wb_data, 32'h0);

    check32("model_mul", ref_md(MD_MUL, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    check32("model_mulhsu", ref_md(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    check32("model_rem", ref_md(MD_REM, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].f, vt[i].a, vt[i].b, vt[i].d, vt[i].k, vt[i].r, vt[i].bs,
             lat, data, addr, seen, idle_at);
      check1($sformatf("t%0d_seen", i), seen, vt[i].es);
      if (vt[i].es) begin
        check32($sformatf("t%0d_lat", i), 32'(lat), 32'(vt[i].el));
        check32($sformatf("t%0d_data", i), data, vt[i].ed);
        check32($sformatf("t%0d_addr", i), {27'b0, addr}, {27'b0, vt[i].d});
      end
      check32($sformatf("t%0d_idle", i), 32'(idle_at), 32'(vt[i].ei));
    end

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int sel, k, bs;
      f   = 3'($urandom);
      sel = $urandom_range(0, 6);
      a   = $urandom;
      b   = $urandom;
      if (sel == 3) begin
        a = $urandom_range(0, 50);
        b = $urandom_range(0, 9);
      end else if (sel == 4) begin
        b = '0;
      end else if (sel == 5) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end else if (sel == 6) begin
        a = -32'($urandom_range(1, 1000));
        b = -32'($urandom_range(1, 20));
      end
      k  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 34) - 1 : 0;
      bs = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 30) : 0;
      run_op(f, a, b, 5'($urandom), k, 0, bs, lat, data, addr, seen, idle_at);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_muldiv.md
# rv_muldiv

Iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for the SCCPU. It sits directly upstream of the register-file write port. It accepts operands already read from the RF together with a destination index. It stalls the core while computing, then drives a one-cycle register write (RFWr/A3/WD equivalents).

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  in  32  operand 1, RF RD1.
- rs2_val  in  32  operand 2, RF RD2.
- rd  in  5  destination register index.
- kill  in  1  abort the current operation; no writeback.
- busy  out  1  high whenever state ≠ IDLE.
- wb_en  out  1  RF write enable; one-cycle pulse.
- wb_addr  out  5  RF write address.
- wb_data  out  32  RF write data.

## Operation
- States:
  - IDLE: start=1 and kill=0 captures funct3, rd, operand magnitudes and the result-sign flags. Next state is RUN, or DONE on the fast path.
  - RUN: 32 iterations, 5-bit counter 0..31.
    - Multiply: shift-add on the unsigned magnitudes, 64-bit accumulator.
    - Divide: restoring division on the magnitudes, 32-bit quotient and remainder.
  - RUN exits to DONE after count 31.
  - DONE: sign-fix the result, drive the write, return to IDLE.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV and REM: both signed.
- Result sign:
  - Product and quotient are negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Result selection:
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
- Fast path (skips RUN, goes straight to DONE):
  - Divide by zero: quotient = 0xFFFFFFFF (signed and unsigned), remainder = dividend.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, DIV or REM): quotient = 0x80000000, remainder = 0.
- Writeback:
  - wb_en = 1 in DONE only, and only when rd ≠ 0. For rd = 0, DONE still occurs with wb_en = 0.
  - wb_addr and wb_data are registered and held stable until the next DONE.
- Priority and corner cases:
  - rst has top priority.
  - kill in RUN or DONE forces IDLE next cycle and suppresses wb_en in that cycle.
  - kill and start together in IDLE: the start is ignored.
  - start while busy is ignored; operands are not re-sampled.
- Reset values: state IDLE, busy 0, wb_en 0, wb_addr 0, wb_data 0, counter 0. rst asserted mid-operation discards all work.

## Timing
- start is accepted at edge T.
- Normal path:
  - busy = 1 for cycles T+1..T+33.
  - RUN occupies T+1..T+32.
  - DONE with wb_en occurs at T+33; the RF captures the write at edge T+34.
  - IDLE at T+34, which can accept a new start at edge T+34.
- Fast path: DONE and wb_en at T+1, busy for 1 cycle.
- busy is registered, so the core's stall is start_mdu | busy. The core must hold rs1_val, rs2_val and rd only at edge T.
- Latency is operand-independent: 33 cycles normal, 1 cycle fast path. There is no early termination.

## Structure
- Shared package md_pkg holds:
  - funct3 constants (MD_MUL … MD_REMU).
  - State enum {IDLE, RUN, DONE}.
  - XLEN and the iteration count (32).
- Natural sub-module: md_iter.
  - Contains the shift-add / restoring-divide datapath and its counter, with inputs load, is_div, mag1, mag2.
  - Outputs 64-bit acc and the last flag.
- rv_muldiv keeps the FSM, operand conditioning, special-case detection, sign-fix and writeback registers.

## Test plan
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD, rd = 5 -> wb_en at T+33, wb_addr 5, wb_data 0xFFFFFFEB; busy high T+1..T+33.
- rs1 = rs2 = 0xFFFFFFFF -> MULHU 0xFFFFFFFE; MULH 0x00000000; MULHSU 0xFFFFFFFF; MUL 0x00000001.
- DIV -7/2 -> 0xFFFFFFF9 / 2 gives 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero, each at T+1:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
- Signed overflow, each at T+1:
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Control and reset:
  - kill at T+10 -> no wb_en, busy = 0 at T+11.
  - start during busy ignored.
  - rd = 0 -> DONE without wb_en.
  - rst at T+5 -> all outputs 0 next cycle; a new MUL 3*4 then returns 12.
